// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles a 16-bit instruction (plus an optional operand byte)
// from an 8-bit memory port and hands it to the decoder with a dec_en/stall handshake.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        stall,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic        dec_en,
  output logic [15:0] dec_inst,
  output logic [7:0]  dec_data,
  output logic [15:0] dec_pc
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_HI   = 3'd1,
    FETCH_LO   = 3'd2,
    FETCH_DATA = 3'd3,
    ISSUE      = 3'd4
  } state_t;

  state_t      state_reg;
  logic        mem_req_reg;
  logic        dec_en_reg;
  logic [15:0] pc_reg;
  logic [7:0]  hi_reg;
  logic [7:0]  lo_reg;
  logic [7:0]  data_reg;
  logic        has_data;
  logic [15:0] pc_step;

  // One-argument opcode whose data source lies in 0x02xx/0x03xx carries an operand byte.
  assign has_data = (hi_reg[7:6] == 2'b10) && (hi_reg[2:1] == 2'b01);
  assign pc_step  = has_data ? 16'd3 : 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mem_req_reg <= 1'b0;
      dec_en_reg  <= 1'b0;
      pc_reg      <= RESET_PC;
      hi_reg      <= 8'h00;
      lo_reg      <= 8'h00;
      data_reg    <= 8'h00;
    end else if (pc_load && (state_reg != IDLE)) begin
      // Redirect drops any byte acked this cycle and any held instruction.
      state_reg   <= FETCH_HI;
      mem_req_reg <= 1'b1;
      dec_en_reg  <= 1'b0;
      pc_reg      <= pc_target;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg   <= FETCH_HI;
          mem_req_reg <= 1'b1;
          dec_en_reg  <= 1'b0;
        end
        FETCH_HI: begin
          if (mem_ack) begin
            hi_reg    <= mem_rdata;
            data_reg  <= 8'h00;
            state_reg <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (mem_ack) begin
            lo_reg <= mem_rdata;
            if (has_data) begin
              state_reg <= FETCH_DATA;
            end else begin
              state_reg   <= ISSUE;
              mem_req_reg <= 1'b0;
              dec_en_reg  <= 1'b1;
            end
          end
        end
        FETCH_DATA: begin
          if (mem_ack) begin
            data_reg    <= mem_rdata;
            state_reg   <= ISSUE;
            mem_req_reg <= 1'b0;
            dec_en_reg  <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc_reg      <= pc_reg + pc_step;
            state_reg   <= FETCH_HI;
            mem_req_reg <= 1'b1;
            dec_en_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
          dec_en_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Byte address is the instruction start plus the offset of the byte being fetched.
  always_comb begin
    mem_addr = pc_reg;
    case (state_reg)
      FETCH_LO:   mem_addr = pc_reg + 16'd1;
      FETCH_DATA: mem_addr = pc_reg + 16'd2;
      default:    mem_addr = pc_reg;
    endcase
  end

  assign mem_req  = mem_req_reg;
  assign dec_en   = dec_en_reg;
  assign dec_inst = {hi_reg, lo_reg};
  assign dec_data = data_reg;
  assign dec_pc   = pc_reg;

endmodule
